// File: rtl/watchdog_kicker.sv
// Periodic refresh-key sender for the watchdog: streams a 32-bit key as 8 nibbles over a
// 4-bit valid/ready link and escalates to a sticky fault after repeated missed launches.
//
// state | meaning
// IDLE  | disabled, outputs quiet, interval counter cleared
// RUN   | counting the kick interval and launching key frames
// DONE  | too many consecutive misses; fault asserted until en drops
module watchdog_kicker #(
    parameter logic [31:0] KEY        = 32'hA5C3_5A3C,
    parameter int          PERIOD_W   = 16,
    parameter int          MIN_PERIOD = 16,
    parameter int          MAX_MISSES = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [PERIOD_W-1:0]             period,
    input  logic                            kick_now,
    output logic [3:0]                      tx_data,
    output logic                            tx_last,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            kick_done,
    output logic [$clog2(MAX_MISSES+1)-1:0] miss_cnt,
    output logic                            fault,
    output logic [1:0]                      state
);

    localparam int                  MISS_W   = $clog2(MAX_MISSES+1);
    localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
    localparam logic [MISS_W-1:0]   MISS_MAX = MISS_W'(MAX_MISSES);

    // Encoding matches the watchdog's state_type.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                entry_q, entry_d;

    logic [PERIOD_W-1:0] eff_period;
    logic [PERIOD_W-1:0] term;
    logic                hs;
    logic                frame_end;
    logic                tick;
    logic                request;
    logic [MISS_W-1:0]   miss_base;

    assign eff_period = (period < MIN_P) ? MIN_P : period;
    assign term       = eff_period - PERIOD_W'(1);
    assign hs         = busy_q & tx_ready;
    assign frame_end  = hs & (idx_q == 3'd7);
    assign tick       = (state_q == RUN) & ~entry_q & (cnt_q == term);
    assign request    = tick | kick_now | entry_q;
    assign miss_base  = frame_end ? '0 : miss_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        miss_d  = miss_q;
        entry_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                busy_d = 1'b0;
                miss_d = '0;
                if (en) begin
                    state_d = RUN;
                    entry_d = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    miss_d  = '0;
                end else begin
                    // The entry request restarts the interval like kick_now, so the
                    // second frame lands a full period after the first.
                    if (tick | entry_q | (kick_now & ~busy_q))
                        cnt_d = '0;
                    else
                        cnt_d = cnt_q + PERIOD_W'(1);
                    if (hs)
                        idx_d = idx_q + 3'd1;
                    miss_d = miss_base;
                    if (frame_end) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                    if (request) begin
                        if (busy_q) begin
                            if (miss_base < MISS_MAX)
                                miss_d = miss_base + MISS_W'(1);
                        end else begin
                            busy_d = 1'b1;
                            idx_d  = '0;
                        end
                    end
                    if (miss_d == MISS_MAX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        cnt_d   = cnt_q;
                    end
                end
            end
            DONE: begin
                busy_d = 1'b0;
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    miss_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= '0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
            entry_q <= entry_d;
        end
    end

    // A frame is in flight exactly while tx_valid is high, so busy doubles as tx_valid.
    assign tx_valid  = busy_q;
    assign tx_data   = busy_q ? KEY[5'd28 - {idx_q, 2'b00} +: 4] : 4'h0;
    assign tx_last   = busy_q & (idx_q == 3'd7);
    assign kick_done = done_q;
    assign miss_cnt  = miss_q;
    assign fault     = (state_q == DONE);
    assign state     = state_q;

endmodule

// File: tb/tb_watchdog_kicker.sv
// Scoreboard bench for watchdog_kicker: stimulus pushes expected nibbles/kick_done cycles,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_watchdog_kicker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        kick_now = 1'b0;
    logic        tx_ready = 1'b1;
    logic [15:0] period = 16'd20;
    logic [3:0]  tx_data;
    logic        tx_last;
    logic        tx_valid;
    logic        kick_done;
    logic [1:0]  miss_cnt;
    logic        fault;
    logic [1:0]  state;

    watchdog_kicker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .period    (period),
        .kick_now  (kick_now),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .kick_done (kick_done),
        .miss_cnt  (miss_cnt),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit finished = 0;

    typedef struct {
        logic [3:0] data;
        logic       last;
        int         cyc;
    } nib_t;

    nib_t nq[$];
    int   kq[$];
    nib_t mon_e;
    int   mon_k;
    logic [3:0] key_nib [8] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h5, 4'hA, 4'h3, 4'hC};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_nib(input int i, input int c);
        nib_t n;
        n.data = key_nib[i];
        n.last = (i == 7);
        n.cyc  = c;
        nq.push_back(n);
    endtask

    task automatic push_partial(input int start, input int n);
        for (int i = 0; i < n; i++) push_nib(i, start + i);
    endtask

    task automatic push_frame(input int start);
        push_partial(start, 8);
        kq.push_back(start + 8);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drained(input string tag);
        chk({tag, " nibbles outstanding"}, nq.size(), 0);
        chk({tag, " kick_done outstanding"}, kq.size(), 0);
        nq.delete();
        kq.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        en = 1'b0;
        kick_now = 1'b0;
        @(posedge clk);
        #2;
        chk("rst state", state, 2'd0);
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst tx_data", tx_data, 4'h0);
        chk("rst tx_last", tx_last, 1'b0);
        chk("rst kick_done", kick_done, 1'b0);
        chk("rst miss_cnt", miss_cnt, 2'd0);
        chk("rst fault", fault, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: handshakes and kick_done pulses are matched against the scoreboard.
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (nq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stray nibble @cyc %0d: got %0h, expected none", cyc, tx_data);
            end else begin
                mon_e = nq.pop_front();
                chk("nib data", tx_data, mon_e.data);
                chk("nib last", tx_last, mon_e.last);
                chk("nib cycle", cyc, mon_e.cyc);
            end
        end else if (tx_valid === 1'b1 && nq.size() > 0) begin
            chk("held data", tx_data, nq[0].data);
            chk("held last", tx_last, nq[0].last);
        end
        if (kick_done === 1'b1) begin
            if (kq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stray kick_done @cyc %0d: got 1, expected 0", cyc);
            end else begin
                mon_k = kq.pop_front();
                chk("kick_done cycle", cyc, mon_k);
            end
        end
    end

    initial begin
        int k;

        // T1: two back-to-back-ready frames, 20 cycles apart
        period = 16'd20;
        tx_ready = 1'b1;
        do_reset();
        k = cyc;
        en = 1'b1;
        push_frame(k + 2);
        push_frame(k + 22);
        wait_cyc(k + 1);
        chk("T1 state on entry", state, 2'd1);
        chk("T1 tx_valid on entry", tx_valid, 1'b0);
        wait_cyc(k + 2);
        chk("T1 first tx_valid", tx_valid, 1'b1);
        wait_cyc(k + 35);
        en = 1'b0;
        wait_cyc(k + 37);
        chk("T1 idle after disable", state, 2'd0);
        drained("T1");

        // T2: 5-cycle stall on nibble 3
        do_reset();
        k = cyc;
        en = 1'b1;
        for (int i = 0; i < 3; i++) push_nib(i, k + 2 + i);
        push_nib(3, k + 10);
        for (int i = 4; i < 8; i++) push_nib(i, k + 7 + i);
        kq.push_back(k + 15);
        wait_cyc(k + 5);
        tx_ready = 1'b0;
        wait_cyc(k + 10);
        tx_ready = 1'b1;
        wait_cyc(k + 16);
        chk("T2 miss_cnt", miss_cnt, 2'd0);
        chk("T2 tx_valid after frame", tx_valid, 1'b0);
        en = 1'b0;
        wait_cyc(k + 18);
        drained("T2");

        // T3: receiver never ready -> three misses -> DONE
        period = 16'd16;
        tx_ready = 1'b0;
        do_reset();
        k = cyc;
        en = 1'b1;
        wait_cyc(k + 17);
        chk("T3 miss before tick1", miss_cnt, 2'd0);
        wait_cyc(k + 18);
        chk("T3 miss after tick1", miss_cnt, 2'd1);
        wait_cyc(k + 34);
        chk("T3 miss after tick2", miss_cnt, 2'd2);
        wait_cyc(k + 49);
        chk("T3 miss before tick3", miss_cnt, 2'd2);
        chk("T3 state before fault", state, 2'd1);
        chk("T3 tx_valid before fault", tx_valid, 1'b1);
        wait_cyc(k + 50);
        chk("T3 miss at fault", miss_cnt, 2'd3);
        chk("T3 state DONE", state, 2'd2);
        chk("T3 fault", fault, 1'b1);
        chk("T3 tx_valid aborted", tx_valid, 1'b0);
        wait_cyc(k + 60);
        chk("T3 DONE sticky", state, 2'd2);
        chk("T3 fault sticky", fault, 1'b1);
        en = 1'b0;
        wait_cyc(k + 61);
        chk("T3 idle after disable", state, 2'd0);
        chk("T3 miss cleared", miss_cnt, 2'd0);
        chk("T3 fault cleared", fault, 1'b0);
        tx_ready = 1'b1;
        drained("T3");

        // T4: short and zero periods clamp to 16
        period = 16'd4;
        do_reset();
        k = cyc;
        en = 1'b1;
        push_frame(k + 2);
        push_frame(k + 18);
        wait_cyc(k + 30);
        en = 1'b0;
        wait_cyc(k + 32);
        chk("T4 idle", state, 2'd0);
        period = 16'd0;
        k = cyc;
        en = 1'b1;
        push_frame(k + 2);
        push_frame(k + 18);
        wait_cyc(k + 30);
        en = 1'b0;
        wait_cyc(k + 32);
        drained("T4");

        // T5: kick_now while idle restarts the interval; while busy it is a miss only
        period = 16'd16;
        do_reset();
        k = cyc;
        en = 1'b1;
        push_frame(k + 2);
        push_frame(k + 13);
        push_frame(k + 29);
        push_partial(k + 45, 6);
        wait_cyc(k + 12);
        kick_now = 1'b1;
        wait_cyc(k + 13);
        kick_now = 1'b0;
        wait_cyc(k + 31);
        chk("T5 miss before busy kick", miss_cnt, 2'd0);
        kick_now = 1'b1;
        wait_cyc(k + 32);
        kick_now = 1'b0;
        chk("T5 miss after busy kick", miss_cnt, 2'd1);
        wait_cyc(k + 36);
        chk("T5 miss held in frame", miss_cnt, 2'd1);
        wait_cyc(k + 37);
        chk("T5 miss cleared by done", miss_cnt, 2'd0);
        wait_cyc(k + 50);
        en = 1'b0;
        wait_cyc(k + 52);
        drained("T5");

        // T6a: disable mid-frame, then re-enable
        period = 16'd20;
        do_reset();
        k = cyc;
        en = 1'b1;
        push_partial(k + 2, 5);
        wait_cyc(k + 6);
        en = 1'b0;
        wait_cyc(k + 7);
        chk("T6a state", state, 2'd0);
        chk("T6a tx_valid", tx_valid, 1'b0);
        chk("T6a kick_done", kick_done, 1'b0);
        wait_cyc(k + 10);
        en = 1'b1;
        push_frame(k + 12);
        wait_cyc(k + 12);
        chk("T6a restart nibble", tx_data, 4'hA);
        wait_cyc(k + 25);
        en = 1'b0;
        wait_cyc(k + 27);
        drained("T6a");

        // T6b: same with reset mid-frame
        do_reset();
        k = cyc;
        en = 1'b1;
        push_partial(k + 2, 5);
        wait_cyc(k + 6);
        rst = 1'b1;
        wait_cyc(k + 7);
        chk("T6b state", state, 2'd0);
        chk("T6b tx_valid", tx_valid, 1'b0);
        chk("T6b kick_done", kick_done, 1'b0);
        chk("T6b miss_cnt", miss_cnt, 2'd0);
        rst = 1'b0;
        en = 1'b0;
        wait_cyc(k + 10);
        en = 1'b1;
        push_frame(k + 12);
        wait_cyc(k + 12);
        chk("T6b restart nibble", tx_data, 4'hA);
        wait_cyc(k + 25);
        en = 1'b0;
        wait_cyc(k + 27);
        drained("T6b");

        finished = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        if (!finished) begin
            fails++;
            $display("FAIL timeout: got no finish, expected finish by 100000");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

endmodule
